// File: rtl/debounce_pkg.sv
// Shared defaults and width helpers for the push-button debounce bank.
package debounce_pkg;

   // Default filter and auto-repeat timing, in sampling-clock cycles.
   localparam int unsigned DefStable    = 4;
   localparam int unsigned DefHoldCyc   = 20;
   localparam int unsigned DefRepeatCyc = 5;

   // Stability counter width: it counts 0 .. stable-1.
   function automatic int unsigned cnt_w(input int unsigned stable);
      int unsigned w;
      w = $clog2(stable);
      if (w < 1) w = 1;
      return w;
   endfunction

   // Hold counter width: it must hold the larger of the two reload values.
   function automatic int unsigned hold_w(input int unsigned hold_cyc,
                                          input int unsigned repeat_cyc);
      int unsigned m;
      int unsigned w;
      m = (hold_cyc > repeat_cyc) ? hold_cyc : repeat_cyc;
      w = $clog2(m + 1);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage : debounce_pkg

// File: rtl/debounce_chan.sv
// One button channel: two-flop synchroniser, stability filter, edge pulses
// and optional auto-repeat while the debounced level is held high.
// The release and repeat pulses are named release_p / repeat_p because
// release and repeat are reserved words.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE     = DefStable,
   parameter int unsigned HOLD_CYC   = DefHoldCyc,
   parameter int unsigned REPEAT_CYC = DefRepeatCyc,
   parameter bit          REPEAT_EN  = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic level,
   output logic press,
   output logic release_p,
   output logic repeat_p
);

   localparam int unsigned CntW  = cnt_w(STABLE);
   localparam int unsigned HoldW = hold_w(HOLD_CYC, REPEAT_CYC);

   localparam logic [CntW-1:0]  CntMax   = CntW'(STABLE - 1);
   localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYC - 1);
   localparam logic [HoldW-1:0] RptLoad  = HoldW'(REPEAT_CYC - 1);

   // Elaboration-time legality checks on the timing parameters.
   if (STABLE < 2) begin : g_chk_stable
      $fatal(1, "debounce_chan: STABLE must be >= 2");
   end
   if (HOLD_CYC < 1) begin : g_chk_hold
      $fatal(1, "debounce_chan: HOLD_CYC must be >= 1");
   end
   if (REPEAT_CYC < 1) begin : g_chk_repeat
      $fatal(1, "debounce_chan: REPEAT_CYC must be >= 1");
   end

   logic [1:0]       sync_q;
   logic [1:0]       sync_d;
   logic [CntW-1:0]  cnt_q;
   logic [CntW-1:0]  cnt_d;
   logic [HoldW-1:0] hcnt_q;
   logic [HoldW-1:0] hcnt_d;
   logic             level_q;
   logic             level_d;
   logic             press_q;
   logic             press_d;
   logic             rel_q;
   logic             rel_d;
   logic             rpt_q;
   logic             rpt_d;
   logic             s;

   assign s = sync_q[1];

   // Synchroniser shift: raw pin into stage 0, stage 0 into stage 1.
   always_comb begin
      sync_d = {sync_q[0], btn_raw};
   end

   // Stability filter: level follows s only after STABLE differing samples.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      if (s == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CntMax) begin
         cnt_d   = '0;
         level_d = s;
         press_d = s;
         rel_d   = ~s;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Auto-repeat: press loads the hold delay, zero count fires and reloads.
   // A press cycle always has level_q = 0, so press and repeat never overlap;
   // a release cycle clears the counter before any repeat can fire.
   always_comb begin
      hcnt_d = hcnt_q;
      rpt_d  = 1'b0;
      if (!REPEAT_EN) begin
         hcnt_d = '0;
      end else if (press_d) begin
         hcnt_d = HoldLoad;
      end else if (rel_d || !level_q) begin
         hcnt_d = '0;
      end else if (hcnt_q == '0) begin
         rpt_d  = 1'b1;
         hcnt_d = RptLoad;
      end else begin
         hcnt_d = hcnt_q - HoldW'(1);
      end
   end

   // All channel state, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         hcnt_q  <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         rpt_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         hcnt_q  <= hcnt_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         rpt_q   <= rpt_d;
      end
   end

   assign level     = level_q;
   assign press     = press_q;
   assign release_p = rel_q;
   assign repeat_p  = rpt_q;

endmodule : debounce_chan

// File: rtl/debounce_bank.sv
// Bank of NCH independent debounce channels for the front-panel buttons.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int unsigned       NCH        = 4,
   parameter int unsigned       STABLE     = DefStable,
   parameter int unsigned       HOLD_CYC   = DefHoldCyc,
   parameter int unsigned       REPEAT_CYC = DefRepeatCyc,
   parameter logic [NCH-1:0]    REPEAT_EN  = {NCH{1'b1}}
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NCH-1:0] btn_raw,
   output logic [NCH-1:0] level,
   output logic [NCH-1:0] press,
   output logic [NCH-1:0] release_p,
   output logic [NCH-1:0] repeat_p
);

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      debounce_chan #(
         .STABLE     (STABLE),
         .HOLD_CYC   (HOLD_CYC),
         .REPEAT_CYC (REPEAT_CYC),
         .REPEAT_EN  (REPEAT_EN[i])
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .btn_raw   (btn_raw[i]),
         .level     (level[i]),
         .press     (press[i]),
         .release_p (release_p[i]),
         .repeat_p  (repeat_p[i])
      );
   end

endmodule : debounce_bank
